uart_line_monitor: RTL and testbench

- Synthesizable, parametrised successor to the serial-line assertion checks of the UART verification environment.
- Passively observes one UART serial line (sTX or sIN) using the 16550 baud-x16 enable.
- Decodes frames per the LCR format fields, flags parity, framing and break events, and checks break/idle line rules in hardware.
- Keeps saturating error counters so the same checks run in emulation and as a gate-level bench monitor.

---
 rtl/uart_line_monitor_if.sv | 35 +++
 rtl/uart_line_monitor.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_line_monitor.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_line_monitor_if.sv
// Signal bundle between a UART serial line and its passive monitor.
// The master drives the observed line, baud tick and line-control inputs.
// The slave (the monitor) returns decoded frames, events and error counters.
interface uart_line_monitor_if #(
   parameter int CNT_W = 16
);
   logic             BCLK_EN;
   logic             LINE;
   logic [7:0]       LCR;
   logic             TEMT;
   logic             CLR;
   logic             FRAME_VLD;
   logic [7:0]       FRAME_DATA;
   logic             PE_EVT;
   logic             FE_EVT;
   logic             BI_EVT;
   logic [CNT_W-1:0] PE_CNT;
   logic [CNT_W-1:0] FE_CNT;
   logic [CNT_W-1:0] BI_CNT;
   logic             BRK_VIOL;
   logic             IDLE_VIOL;
   logic             BUSY;

   modport master (
      output BCLK_EN, LINE, LCR, TEMT, CLR,
      input  FRAME_VLD, FRAME_DATA, PE_EVT, FE_EVT, BI_EVT,
             PE_CNT, FE_CNT, BI_CNT, BRK_VIOL, IDLE_VIOL, BUSY
   );

   modport slave (
      input  BCLK_EN, LINE, LCR, TEMT, CLR,
      output FRAME_VLD, FRAME_DATA, PE_EVT, FE_EVT, BI_EVT,
             PE_CNT, FE_CNT, BI_CNT, BRK_VIOL, IDLE_VIOL, BUSY
   );
endinterface

// File: rtl/uart_line_monitor.sv
// Passive UART line monitor.
// Decodes frames on an observed serial line using the 16550 baud-x16 tick,
// reports parity/framing/break events per frame, keeps saturating error
// counters, and checks break and idle line rules.
module uart_line_monitor #(
   parameter int OVS      = 16,
   parameter int CNT_W    = 16,
   parameter int IDLE_TOL = 2
) (
   input logic                PCLK,
   input logic                PRESET,
   uart_line_monitor_if.slave mon
);

   localparam int              TW        = (OVS > 2) ? $clog2(OVS) : 1;
   localparam logic [TW-1:0]   HALF_LAST = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0]   BIT_LAST  = TW'(OVS - 1);
   localparam int              IW        = $clog2(IDLE_TOL + 2);
   localparam logic [IW-1:0]   IDLE_MAX  = IW'(IDLE_TOL + 1);
   localparam logic [IW-1:0]   IDLE_LIM  = IW'(IDLE_TOL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2,
      S_BREAK
   } state_t;

   state_t           state;
   logic [TW-1:0]    tick_cnt;
   logic [2:0]       bit_cnt;

   // frame format captured at start-bit detection
   logic [1:0]       cfg_wls;
   logic             cfg_stb;
   logic             cfg_pen;
   logic             cfg_eps;
   logic             cfg_stick;

   logic [7:0]       data_r;
   logic             par_acc;
   logic             all_low;
   logic             pe_f;
   logic             fe_f;

   logic             frame_vld;
   logic [7:0]       frame_data;
   logic             pe_evt;
   logic             fe_evt;
   logic             bi_evt;
   logic             busy;

   logic [CNT_W-1:0] pe_cnt;
   logic [CNT_W-1:0] fe_cnt;
   logic [CNT_W-1:0] bi_cnt;

   logic             line_s1;
   logic             line_s;
   logic             brk_armed;
   logic             brk_viol;
   logic [IW-1:0]    idle_cnt;
   logic             idle_viol;

   logic             tick;
   logic             bit_done;
   logic [2:0]       last_bit;
   logic             exp_par;
   logic             two_stop;
   logic             idle_watch;
   logic             unused_lcr7;

   assign unused_lcr7 = mon.LCR[7];

   // Two-flop synchroniser for the asynchronous serial line (resets to idle-high)
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         line_s1 <= 1'b1;
         line_s  <= 1'b1;
      end else begin
         line_s1 <= mon.LINE;
         line_s  <= line_s1;
      end
   end

   // Per-frame decode helpers derived from the latched format
   always_comb begin
      tick     = mon.BCLK_EN;
      bit_done = (tick_cnt == BIT_LAST);
      last_bit = 3'd4 + {1'b0, cfg_wls};
      exp_par  = cfg_stick ? ~cfg_eps : (cfg_eps ? par_acc : ~par_acc);
      two_stop = cfg_stb && (cfg_wls != 2'd0);
      // START counts as idle: the start bit is not yet confirmed there
      idle_watch = !mon.LCR[6] && mon.TEMT && !line_s &&
                   ((state == S_IDLE) || (state == S_START));
   end

   // Frame receive FSM with registered frame outputs
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         cfg_wls    <= '0;
         cfg_stb    <= 1'b0;
         cfg_pen    <= 1'b0;
         cfg_eps    <= 1'b0;
         cfg_stick  <= 1'b0;
         data_r     <= '0;
         par_acc    <= 1'b0;
         all_low    <= 1'b0;
         pe_f       <= 1'b0;
         fe_f       <= 1'b0;
         frame_vld  <= 1'b0;
         frame_data <= '0;
         pe_evt     <= 1'b0;
         fe_evt     <= 1'b0;
         bi_evt     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_vld <= 1'b0;
         pe_evt    <= 1'b0;
         fe_evt    <= 1'b0;
         bi_evt    <= 1'b0;
         if (tick) begin
            case (state)
               S_IDLE: begin
                  if (!line_s) begin
                     state     <= S_START;
                     tick_cnt  <= '0;
                     cfg_wls   <= mon.LCR[1:0];
                     cfg_stb   <= mon.LCR[2];
                     cfg_pen   <= mon.LCR[3];
                     cfg_eps   <= mon.LCR[4];
                     cfg_stick <= mon.LCR[5];
                     busy      <= 1'b1;
                  end
               end
               S_START: begin
                  if (tick_cnt == HALF_LAST) begin
                     tick_cnt <= '0;
                     if (!line_s) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        data_r  <= '0;
                        par_acc <= 1'b0;
                        all_low <= 1'b1;
                        pe_f    <= 1'b0;
                        fe_f    <= 1'b0;
                     end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_DATA: begin
                  if (bit_done) begin
                     tick_cnt        <= '0;
                     data_r[bit_cnt] <= line_s;
                     par_acc         <= par_acc ^ line_s;
                     all_low         <= all_low & ~line_s;
                     if (bit_cnt == last_bit) begin
                        state <= cfg_pen ? S_PARITY : S_STOP1;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_PARITY: begin
                  if (bit_done) begin
                     tick_cnt <= '0;
                     pe_f     <= (line_s != exp_par);
                     all_low  <= all_low & ~line_s;
                     state    <= S_STOP1;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_STOP1: begin
                  if (bit_done) begin
                     tick_cnt <= '0;
                     if (all_low && !line_s) begin
                        // break overrides parity and framing on this frame
                        state      <= S_BREAK;
                        frame_vld  <= 1'b1;
                        frame_data <= data_r;
                        bi_evt     <= 1'b1;
                     end else if (two_stop) begin
                        fe_f  <= ~line_s;
                        state <= S_STOP2;
                     end else begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        frame_vld  <= 1'b1;
                        frame_data <= data_r;
                        pe_evt     <= pe_f;
                        fe_evt     <= ~line_s;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_STOP2: begin
                  if (bit_done) begin
                     tick_cnt   <= '0;
                     state      <= S_IDLE;
                     busy       <= 1'b0;
                     frame_vld  <= 1'b1;
                     frame_data <= data_r;
                     pe_evt     <= pe_f;
                     fe_evt     <= fe_f | ~line_s;
                  end else begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
               end
               S_BREAK: begin
                  if (line_s) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating error counters; a coincident clear takes priority
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         pe_cnt <= '0;
         fe_cnt <= '0;
         bi_cnt <= '0;
      end else if (mon.CLR) begin
         pe_cnt <= '0;
         fe_cnt <= '0;
         bi_cnt <= '0;
      end else if (frame_vld) begin
         if (pe_evt && (pe_cnt != '1)) pe_cnt <= pe_cnt + CNT_W'(1);
         if (fe_evt && (fe_cnt != '1)) fe_cnt <= fe_cnt + CNT_W'(1);
         if (bi_evt && (bi_cnt != '1)) bi_cnt <= bi_cnt + CNT_W'(1);
      end
   end

   // Break-control rule: line must stay low while BRKC is set (one tick grace)
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         brk_armed <= 1'b0;
         brk_viol  <= 1'b0;
      end else begin
         if (tick) brk_armed <= mon.LCR[6];
         if (mon.CLR) begin
            brk_viol <= 1'b0;
         end else if (tick && mon.LCR[6] && brk_armed && line_s) begin
            brk_viol <= 1'b1;
         end
      end
   end

   // Idle rule: with the transmitter empty the line may dip low only briefly
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         idle_cnt  <= '0;
         idle_viol <= 1'b0;
      end else begin
         if (tick) begin
            if (!idle_watch) begin
               idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
               idle_cnt <= idle_cnt + IW'(1);
            end
         end
         if (mon.CLR) begin
            idle_viol <= 1'b0;
         end else if (tick && idle_watch && (idle_cnt >= IDLE_LIM)) begin
            idle_viol <= 1'b1;
         end
      end
   end

   assign mon.FRAME_VLD  = frame_vld;
   assign mon.FRAME_DATA = frame_data;
   assign mon.PE_EVT     = pe_evt;
   assign mon.FE_EVT     = fe_evt;
   assign mon.BI_EVT     = bi_evt;
   assign mon.PE_CNT     = pe_cnt;
   assign mon.FE_CNT     = fe_cnt;
   assign mon.BI_CNT     = bi_cnt;
   assign mon.BRK_VIOL   = brk_viol;
   assign mon.IDLE_VIOL  = idle_viol;
   assign mon.BUSY       = busy;

endmodule

// File: tb/tb_uart_line_monitor.sv
// Self-checking bench for uart_line_monitor.
// Two monitors share one line: a 16-bit-counter instance checked in full and
// a 2-bit-counter instance used for counter saturation.
module tb_uart_line_monitor;

   localparam int OVS = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bi;
   } frm_t;

   logic PCLK = 1'b0;
   logic PRESET;
   int   checks = 0;
   int   errors = 0;
   int   n_pe = 0;
   int   n_fe = 0;
   int   n_bi = 0;
   frm_t q[$];

   always #5 PCLK = ~PCLK;

   uart_line_monitor_if #(.CNT_W(16)) mon ();
   uart_line_monitor_if #(.CNT_W(2))  mon_s ();

   uart_line_monitor #(.OVS(OVS), .CNT_W(16), .IDLE_TOL(2)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .mon(mon)
   );
   uart_line_monitor #(.OVS(OVS), .CNT_W(2), .IDLE_TOL(2)) dut_s (
      .PCLK(PCLK), .PRESET(PRESET), .mon(mon_s)
   );

   assign mon_s.BCLK_EN = mon.BCLK_EN;
   assign mon_s.LINE    = mon.LINE;
   assign mon_s.LCR     = mon.LCR;
   assign mon_s.TEMT    = mon.TEMT;
   assign mon_s.CLR     = mon.CLR;

   // capture every completed frame away from the active edge
   always @(negedge PCLK) begin
      if (mon.FRAME_VLD === 1'b1)
         q.push_back({mon.FRAME_DATA, mon.PE_EVT, mon.FE_EVT, mon.BI_EVT});
   end

   function automatic int sat(input int n, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // one oversample tick: line settles through the synchroniser first
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (2) @(negedge PCLK);
         mon.BCLK_EN = 1'b1;
         @(negedge PCLK);
         mon.BCLK_EN = 1'b0;
      end
   endtask

   task automatic hold(input logic lvl, input int n);
      mon.LINE = lvl;
      tick(n);
   endtask

   task automatic pulse_clr();
      @(negedge PCLK);
      mon.CLR = 1'b1;
      @(negedge PCLK);
      mon.CLR = 1'b0;
      n_pe = 0;
      n_fe = 0;
      n_bi = 0;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_pecnt"},   32'(mon.PE_CNT),   sat(n_pe, 16));
      check({tag, "_fecnt"},   32'(mon.FE_CNT),   sat(n_fe, 16));
      check({tag, "_bicnt"},   32'(mon.BI_CNT),   sat(n_bi, 16));
      check({tag, "_pecnt_s"}, 32'(mon_s.PE_CNT), sat(n_pe, 2));
      check({tag, "_fecnt_s"}, 32'(mon_s.FE_CNT), sat(n_fe, 2));
      check({tag, "_bicnt_s"}, 32'(mon_s.BI_CNT), sat(n_bi, 2));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vld"},   32'(mon.FRAME_VLD),  0);
      check({tag, "_data"},  32'(mon.FRAME_DATA), 0);
      check({tag, "_evts"},  32'({mon.PE_EVT, mon.FE_EVT, mon.BI_EVT}), 0);
      check({tag, "_cnts"},  32'(mon.PE_CNT) | 32'(mon.FE_CNT) | 32'(mon.BI_CNT), 0);
      check({tag, "_viols"}, 32'({mon.BRK_VIOL, mon.IDLE_VIOL}), 0);
      check({tag, "_busy"},  32'(mon.BUSY), 0);
      check({tag, "_s"}, 32'({mon_s.FRAME_VLD, mon_s.FRAME_DATA, mon_s.PE_EVT, mon_s.FE_EVT,
                              mon_s.BI_EVT, mon_s.PE_CNT, mon_s.FE_CNT, mon_s.BI_CNT,
                              mon_s.BRK_VIOL, mon_s.IDLE_VIOL, mon_s.BUSY}), 0);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] d,
                               input bit pe, input bit fe, input bit bi);
      frm_t f;
      check({tag, "_nfrm"}, q.size(), 1);
      if (q.size() > 0) begin
         f = q.pop_front();
         check({tag, "_data"}, 32'(f.d),  32'(d));
         check({tag, "_pe"},   32'(f.pe), 32'(pe));
         check({tag, "_fe"},   32'(f.fe), 32'(fe));
         check({tag, "_bi"},   32'(f.bi), 32'(bi));
      end
      q.delete();
      n_pe += int'(pe);
      n_fe += int'(fe);
      n_bi += int'(bi);
      check_counts(tag);
   endtask

   // drive one frame bit by bit and compare against the format rules
   task automatic send_frame(input string tag, input logic [7:0] lcr, input logic [7:0] d,
                             input bit par_err, input bit s1, input bit s2, input bit scramble);
      int         nb;
      int         ones;
      bit         pen, eps, stick, stb, two_stop, half, good_par, par, bi, pe, fe;
      logic [7:0] mask, dm;
      nb       = 5 + int'(lcr[1:0]);
      mask     = 8'hFF >> (8 - nb);
      dm       = d & mask;
      pen      = lcr[3];
      eps      = lcr[4];
      stick    = lcr[5];
      stb      = lcr[2];
      two_stop = stb && (nb != 5);
      half     = stb && (nb == 5);
      ones     = $countones(dm);
      if (stick)    good_par = !eps;
      else if (eps) good_par = (ones % 2) == 1;
      else          good_par = (ones % 2) == 0;
      par = good_par ^ par_err;
      bi  = (dm == 8'h00) && (!pen || !par) && !s1;
      pe  = !bi && pen && par_err;
      fe  = !bi && (!s1 || (two_stop && !s2));

      mon.LCR = lcr;
      hold(1'b0, OVS);
      if (scramble) mon.LCR = 8'($urandom) & 8'hBF;
      for (int i = 0; i < nb; i++) hold(dm[i], OVS);
      check({tag, "_busy"}, 32'(mon.BUSY), 1);
      if (pen) hold(par, OVS);
      hold(s1, OVS);
      if (two_stop) hold(s2, OVS);
      else if (half) hold(s2, OVS / 2);
      hold(1'b1, OVS + 8);
      mon.LCR = lcr;
      expect_frame(tag, dm, pe, fe, bi);
   endtask

   initial begin
      logic [7:0] lcr, d;
      bit         pe_r, s1_r, s2_r;

      PRESET      = 1'b1;
      mon.BCLK_EN = 1'b0;
      mon.LINE    = 1'b1;
      mon.LCR     = 8'h03;
      mon.TEMT    = 1'b0;
      mon.CLR     = 1'b0;
      repeat (3) @(negedge PCLK);
      check_all_zero("reset");
      PRESET = 1'b0;
      hold(1'b1, 8);

      // 8N1 clean frame
      send_frame("8n1_55", 8'h03, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0);

      // 7E1 parity error, then correct parity
      send_frame("7e1_bad", 8'h1A, 8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
      send_frame("7e1_good", 8'h1A, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0);

      // 8N2 low second stop, then 5N1.5 low half stop
      send_frame("8n2_fe", 8'h07, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame("5n15", 8'h04, 8'h15, 1'b0, 1'b1, 1'b0, 1'b0);

      // line held low for two frame times
      mon.LCR = 8'h03;
      hold(1'b0, 2 * 10 * OVS);
      check("brk_busy_low", 32'(mon.BUSY), 1);
      expect_frame("brk", 8'h00, 1'b0, 1'b0, 1'b1);
      hold(1'b1, 1);
      check("brk_busy_high", 32'(mon.BUSY), 0);
      hold(1'b1, OVS);
      send_frame("after_brk", 8'h03, 8'hC6, 1'b0, 1'b1, 1'b1, 1'b0);

      // short low pulses in idle
      hold(1'b0, 4);
      hold(1'b1, 20);
      check("glitch_nfrm", q.size(), 0);
      check("glitch_idle_viol", 32'(mon.IDLE_VIOL), 0);
      mon.TEMT = 1'b1;
      hold(1'b0, 2);
      hold(1'b1, 20);
      check("idle_tol_edge", 32'(mon.IDLE_VIOL), 0);
      hold(1'b0, 3);
      hold(1'b1, 20);
      mon.TEMT = 1'b0;
      check("idle_viol_set", 32'(mon.IDLE_VIOL), 1);
      check("idle_nfrm", q.size(), 0);
      pulse_clr();
      check("idle_viol_clr", 32'(mon.IDLE_VIOL), 0);
      check_counts("clr");

      // break-control rule
      mon.LCR = 8'h43;
      hold(1'b1, 1);
      mon.LCR = 8'h03;
      hold(1'b1, 1);
      check("brk_grace", 32'(mon.BRK_VIOL), 0);
      mon.LCR = 8'h43;
      hold(1'b0, 3);
      check("brk_low_ok", 32'(mon.BRK_VIOL), 0);
      hold(1'b1, 1);
      check("brk_viol_set", 32'(mon.BRK_VIOL), 1);
      mon.LCR = 8'h03;
      hold(1'b1, 20);
      check("brk_viol_sticky", 32'(mon.BRK_VIOL), 1);
      check("brk_nfrm", q.size(), 0);
      pulse_clr();
      check("brk_viol_clr", 32'(mon.BRK_VIOL), 0);

      // four parity errors: 2-bit counter saturates
      for (int i = 0; i < 4; i++)
         send_frame($sformatf("sat%0d", i), 8'h1A, 8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);

      // randomized formats and error injection, LCR disturbed mid-frame
      for (int i = 0; i < 24; i++) begin
         lcr  = {2'b00, 6'($urandom)};
         d    = 8'($urandom);
         pe_r = ($urandom_range(0, 3) == 0);
         s1_r = ($urandom_range(0, 5) != 0);
         s2_r = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 7) == 0) begin
            d    = 8'h00;
            s1_r = ($urandom_range(0, 1) == 0);
         end
         if (lcr[2] && (lcr[1:0] == 2'b00)) s2_r = 1'b1;
         send_frame($sformatf("rnd%0d", i), lcr, d, pe_r, s1_r, s2_r, 1'b1);
      end

      // reset in the middle of the data bits
      mon.LCR = 8'h03;
      hold(1'b0, OVS);
      hold(1'b1, OVS);
      hold(1'b0, OVS);
      hold(1'b1, OVS / 2);
      @(negedge PCLK);
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);
      check_all_zero("mid_rst");
      PRESET = 1'b0;
      n_pe = 0;
      n_fe = 0;
      n_bi = 0;
      hold(1'b1, 12 * OVS);
      check("mid_rst_nfrm", q.size(), 0);
      check("mid_rst_busy", 32'(mon.BUSY), 0);
      check_counts("mid_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
